// File: rtl/bullet_ctrl.sv
// rtl/bullet_ctrl.sv - two-player bullet engine: spawn, move, wall/tank hits, block destroy, pixel masks
module bullet_ctrl #(
  parameter int BULLET_SPEED  = 2,
  parameter int BULLET_SIZE   = 4,
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int EXPLODE_STEPS = 8,
  parameter int HIT_LO        = 3,
  parameter int HIT_HI        = 28
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       step_en_i,
  input  logic       player_1_shoot_i,
  input  logic       player_2_shoot_i,
  input  logic [9:0] player_1_x_i,
  input  logic [9:0] player_1_y_i,
  input  logic [9:0] player_2_x_i,
  input  logic [9:0] player_2_y_i,
  input  logic [3:0] player_1_dir_i,
  input  logic [3:0] player_2_dir_i,
  input  logic [9:0] hpos_i,
  input  logic [9:0] vpos_i,
  input  logic       display_enable_i,
  input  logic       block_bullet_i,
  input  logic       destroyable_block_i,
  output logic [9:0] bullet_1_x_o,
  output logic [9:0] bullet_1_y_o,
  output logic [9:0] bullet_2_x_o,
  output logic [9:0] bullet_2_y_o,
  output logic [1:0] bullet_1_state_o,
  output logic [1:0] bullet_2_state_o,
  output logic       bullet_pixel_o,
  output logic       explode_pixel_o,
  output logic       hit_p1_o,
  output logic       hit_p2_o,
  output logic       destroy_o,
  output logic [4:0] destroy_col_o,
  output logic [3:0] destroy_row_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_FLY  = 2'b01,
    S_EXPL = 2'b10
  } state_t;

  localparam int CW = (EXPLODE_STEPS > 1) ? $clog2(EXPLODE_STEPS) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(EXPLODE_STEPS - 1);
  localparam logic [9:0]  SPEED10 = 10'(BULLET_SPEED);
  localparam logic [9:0]  SPAWN10 = 10'd14;
  localparam logic [10:0] SPEED11 = 11'(BULLET_SPEED);
  localparam logic [10:0] SIZE_M1 = 11'(BULLET_SIZE - 1);
  localparam logic [10:0] HIT_LO11 = 11'(HIT_LO);
  localparam logic [10:0] HIT_HI11 = 11'(HIT_HI);
  localparam logic [10:0] H_LIM = 11'(H_ACTIVE - BULLET_SIZE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE - BULLET_SIZE);

  // Index 0 is player 1's bullet, index 1 is player 2's; the enemy of bullet i is tank 1-i.
  state_t        state_q [2];
  state_t        state_d [2];
  logic [9:0]    x_q     [2];
  logic [9:0]    x_d     [2];
  logic [9:0]    y_q     [2];
  logic [9:0]    y_d     [2];
  logic [3:0]    dir_q   [2];
  logic [3:0]    dir_d   [2];
  logic          wall_q  [2];
  logic          wall_d  [2];
  logic          destr_q [2];
  logic          destr_d [2];
  logic [CW-1:0] cnt_q   [2];
  logic [CW-1:0] cnt_d   [2];
  logic          shoot_q [2];
  logic          shoot_d [2];
  logic          hit_q   [2];
  logic          hit_d   [2];

  logic       dest_q, dest_d;
  logic [4:0] dcol_q, dcol_d;
  logic [3:0] drow_q, drow_d;
  logic       pend_q, pend_d;
  logic [4:0] pcol_q, pcol_d;
  logic [3:0] prow_q, prow_d;

  logic [9:0]  px       [2];
  logic [9:0]  py       [2];
  logic [9:0]  ex       [2];
  logic [9:0]  ey       [2];
  logic [3:0]  dir_in   [2];
  logic        shoot_in [2];
  logic [10:0] bx11     [2];
  logic [10:0] by11     [2];
  logic        in_box   [2];
  logic        pix_wall [2];
  logic        wall_now [2];
  logic        destr_now[2];
  logic        enemy_hit[2];
  logic        oob      [2];
  logic        fire     [2];
  logic        dir_ok   [2];
  logic        dest_req [2];
  logic [4:0]  req_col  [2];
  logic [3:0]  req_row  [2];

  always_comb begin
    px[0]       = player_1_x_i;
    py[0]       = player_1_y_i;
    px[1]       = player_2_x_i;
    py[1]       = player_2_y_i;
    ex[0]       = player_2_x_i;
    ey[0]       = player_2_y_i;
    ex[1]       = player_1_x_i;
    ey[1]       = player_1_y_i;
    dir_in[0]   = player_1_dir_i;
    dir_in[1]   = player_2_dir_i;
    shoot_in[0] = player_1_shoot_i;
    shoot_in[1] = player_2_shoot_i;
  end

  // Per-bullet geometry, evaluated in 11 bits so no sum can wrap.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      bx11[i]      = {1'b0, x_q[i]};
      by11[i]      = {1'b0, y_q[i]};
      in_box[i]    = ({1'b0, hpos_i} >= bx11[i]) && ({1'b0, hpos_i} <= bx11[i] + SIZE_M1) &&
                     ({1'b0, vpos_i} >= by11[i]) && ({1'b0, vpos_i} <= by11[i] + SIZE_M1);
      pix_wall[i]  = display_enable_i && block_bullet_i && in_box[i] && (state_q[i] == S_FLY);
      wall_now[i]  = wall_q[i] | pix_wall[i];
      destr_now[i] = destr_q[i] | (pix_wall[i] & destroyable_block_i);
      enemy_hit[i] = (bx11[i] + SIZE_M1 >= {1'b0, ex[i]} + HIT_LO11) &&
                     (bx11[i] <= {1'b0, ex[i]} + HIT_HI11) &&
                     (by11[i] + SIZE_M1 >= {1'b0, ey[i]} + HIT_LO11) &&
                     (by11[i] <= {1'b0, ey[i]} + HIT_HI11);
      oob[i]       = (dir_q[i][1] && (by11[i] < SPEED11)) ||
                     (dir_q[i][3] && (bx11[i] < SPEED11)) ||
                     (dir_q[i][0] && (by11[i] + SPEED11 > V_LIM)) ||
                     (dir_q[i][2] && (bx11[i] + SPEED11 > H_LIM));
      fire[i]      = shoot_in[i] & ~shoot_q[i];
      dir_ok[i]    = dir_in[i] inside {4'b0001, 4'b0010, 4'b0100, 4'b1000};
      req_col[i]   = 5'((bx11[i] + 11'd2) >> 5);
      req_row[i]   = 4'((by11[i] + 11'd2) >> 5);
    end
  end

  always_comb begin
    hit_d[0] = 1'b0;
    hit_d[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      state_d[i]  = state_q[i];
      x_d[i]      = x_q[i];
      y_d[i]      = y_q[i];
      dir_d[i]    = dir_q[i];
      wall_d[i]   = 1'b0;
      destr_d[i]  = 1'b0;
      cnt_d[i]    = cnt_q[i];
      shoot_d[i]  = shoot_in[i];
      dest_req[i] = 1'b0;
      case (state_q[i])
        S_IDLE: begin
          if (fire[i] && dir_ok[i]) begin
            state_d[i] = S_FLY;
            x_d[i]     = px[i] + SPAWN10;
            y_d[i]     = py[i] + SPAWN10;
            dir_d[i]   = dir_in[i];
          end
        end
        S_FLY: begin
          if (!step_en_i) begin
            wall_d[i]  = wall_now[i];
            destr_d[i] = destr_now[i];
          end else if (enemy_hit[i]) begin
            hit_d[1-i] = 1'b1;
            state_d[i] = S_EXPL;
            cnt_d[i]   = CNT_LOAD;
          end else if (wall_now[i]) begin
            state_d[i]  = S_EXPL;
            cnt_d[i]    = CNT_LOAD;
            dest_req[i] = destr_now[i];
          end else if (oob[i]) begin
            state_d[i] = S_IDLE;
          end else begin
            case (dir_q[i])
              4'b0001: y_d[i] = y_q[i] + SPEED10;
              4'b0010: y_d[i] = y_q[i] - SPEED10;
              4'b0100: x_d[i] = x_q[i] + SPEED10;
              4'b1000: x_d[i] = x_q[i] - SPEED10;
              default: state_d[i] = S_IDLE;
            endcase
          end
        end
        S_EXPL: begin
          if (step_en_i) begin
            if (cnt_q[i] == '0) state_d[i] = S_IDLE;
            else                cnt_d[i]   = cnt_q[i] - 1'b1;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  // Bullet 1 wins the destroy port; a coincident bullet 2 request waits one cycle.
  always_comb begin
    dest_d = 1'b0;
    dcol_d = dcol_q;
    drow_d = drow_q;
    pend_d = pend_q;
    pcol_d = pcol_q;
    prow_d = prow_q;
    if (dest_req[0]) begin
      dest_d = 1'b1;
      dcol_d = req_col[0];
      drow_d = req_row[0];
      if (dest_req[1]) begin
        pend_d = 1'b1;
        pcol_d = req_col[1];
        prow_d = req_row[1];
      end
    end else if (dest_req[1]) begin
      dest_d = 1'b1;
      dcol_d = req_col[1];
      drow_d = req_row[1];
    end else if (pend_q) begin
      dest_d = 1'b1;
      dcol_d = pcol_q;
      drow_d = prow_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= S_IDLE;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        dir_q[i]   <= '0;
        wall_q[i]  <= 1'b0;
        destr_q[i] <= 1'b0;
        cnt_q[i]   <= '0;
        shoot_q[i] <= 1'b0;
        hit_q[i]   <= 1'b0;
      end
      dest_q <= 1'b0;
      dcol_q <= '0;
      drow_q <= '0;
      pend_q <= 1'b0;
      pcol_q <= '0;
      prow_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
        dir_q[i]   <= dir_d[i];
        wall_q[i]  <= wall_d[i];
        destr_q[i] <= destr_d[i];
        cnt_q[i]   <= cnt_d[i];
        shoot_q[i] <= shoot_d[i];
        hit_q[i]   <= hit_d[i];
      end
      dest_q <= dest_d;
      dcol_q <= dcol_d;
      drow_q <= drow_d;
      pend_q <= pend_d;
      pcol_q <= pcol_d;
      prow_q <= prow_d;
    end
  end

  assign bullet_1_x_o     = x_q[0];
  assign bullet_1_y_o     = y_q[0];
  assign bullet_2_x_o     = x_q[1];
  assign bullet_2_y_o     = y_q[1];
  assign bullet_1_state_o = state_q[0];
  assign bullet_2_state_o = state_q[1];
  assign hit_p1_o         = hit_q[0];
  assign hit_p2_o         = hit_q[1];
  assign destroy_o        = dest_q;
  assign destroy_col_o    = dcol_q;
  assign destroy_row_o    = drow_q;

  assign bullet_pixel_o  = display_enable_i &&
                           (((state_q[0] == S_FLY) && in_box[0]) || ((state_q[1] == S_FLY) && in_box[1]));
  assign explode_pixel_o = display_enable_i &&
                           (((state_q[0] == S_EXPL) && in_box[0]) || ((state_q[1] == S_EXPL) && in_box[1]));

endmodule

// File: tb/tb_bullet_ctrl.sv
// tb/tb_bullet_ctrl.sv - self-checking bench for bullet_ctrl
module tb_bullet_ctrl;

  logic       clk = 1'b0;
  logic       rst, step, sh1, sh2, de, blk, dst;
  logic [9:0] p1x, p1y, p2x, p2y, hpos, vpos;
  logic [3:0] p1d, p2d;
  logic [9:0] b1x, b1y, b2x, b2y;
  logic [1:0] s1, s2;
  logic       bp, ep, h1, h2, d;
  logic [4:0] col;
  logic [3:0] row;

  always #5 clk = ~clk;

  bullet_ctrl dut (
    .clk_i(clk), .reset_i(rst), .step_en_i(step),
    .player_1_shoot_i(sh1), .player_2_shoot_i(sh2),
    .player_1_x_i(p1x), .player_1_y_i(p1y), .player_2_x_i(p2x), .player_2_y_i(p2y),
    .player_1_dir_i(p1d), .player_2_dir_i(p2d),
    .hpos_i(hpos), .vpos_i(vpos), .display_enable_i(de),
    .block_bullet_i(blk), .destroyable_block_i(dst),
    .bullet_1_x_o(b1x), .bullet_1_y_o(b1y), .bullet_2_x_o(b2x), .bullet_2_y_o(b2y),
    .bullet_1_state_o(s1), .bullet_2_state_o(s2),
    .bullet_pixel_o(bp), .explode_pixel_o(ep),
    .hit_p1_o(h1), .hit_p2_o(h2),
    .destroy_o(d), .destroy_col_o(col), .destroy_row_o(row)
  );

  typedef struct {
    string tag;
    int s1, x1, y1, s2, x2, y2, h1, h2, d, col, row;
  } snap_t;

  typedef struct {
    int h, v, de, bp, ep;
  } pix_t;

  snap_t sb[$];
  pix_t  ptab[7];
  int    checks = 0;
  int    errors = 0;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // exp < 0 marks a field the sequence does not care about
  task automatic cmp_opt(input string name, input int act, input int exp);
    if (exp >= 0) cmp(name, act, exp);
  endtask

  task automatic expect_snap(input string tag, input int es1, input int ex1, input int ey1,
                             input int es2, input int ex2, input int ey2,
                             input int eh1, input int eh2, input int ed,
                             input int ecol, input int erow);
    snap_t s;
    s.tag = tag;
    s.s1 = es1; s.x1 = ex1; s.y1 = ey1;
    s.s2 = es2; s.x2 = ex2; s.y2 = ey2;
    s.h1 = eh1; s.h2 = eh2; s.d = ed; s.col = ecol; s.row = erow;
    sb.push_back(s);
  endtask

  task automatic check_snap();
    snap_t s;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: no expected entry, got 0 expected 1");
    end else begin
      s = sb.pop_front();
      cmp_opt({s.tag, ".s1"}, int'(s1), s.s1);
      cmp_opt({s.tag, ".x1"}, int'(b1x), s.x1);
      cmp_opt({s.tag, ".y1"}, int'(b1y), s.y1);
      cmp_opt({s.tag, ".s2"}, int'(s2), s.s2);
      cmp_opt({s.tag, ".x2"}, int'(b2x), s.x2);
      cmp_opt({s.tag, ".y2"}, int'(b2y), s.y2);
      cmp_opt({s.tag, ".hit_p1"}, int'(h1), s.h1);
      cmp_opt({s.tag, ".hit_p2"}, int'(h2), s.h2);
      cmp_opt({s.tag, ".destroy"}, int'(d), s.d);
      cmp_opt({s.tag, ".col"}, int'(col), s.col);
      cmp_opt({s.tag, ".row"}, int'(row), s.row);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    expect_snap(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    check_snap();
    hpos = 10'd1; vpos = 10'd1; de = 1'b1;
    #1;
    cmp({tag, ".bullet_pixel"}, int'(bp), 0);
    cmp({tag, ".explode_pixel"}, int'(ep), 0);
    de = 1'b0;
  endtask

  initial begin
    rst = 1'b1; step = 1'b0; sh1 = 1'b0; sh2 = 1'b0;
    de = 1'b0; blk = 1'b0; dst = 1'b0; hpos = '0; vpos = '0;
    p1x = 10'd224; p1y = 10'd32; p1d = 4'b0001;
    p2x = 10'd500; p2y = 10'd400; p2d = 4'b0001;

    ptab[0] = '{h: 238, v: 66, de: 1, bp: 1, ep: 0};
    ptab[1] = '{h: 241, v: 69, de: 1, bp: 1, ep: 0};
    ptab[2] = '{h: 242, v: 66, de: 1, bp: 0, ep: 0};
    ptab[3] = '{h: 237, v: 66, de: 1, bp: 0, ep: 0};
    ptab[4] = '{h: 238, v: 70, de: 1, bp: 0, ep: 0};
    ptab[5] = '{h: 240, v: 68, de: 0, bp: 0, ep: 0};
    ptab[6] = '{h: 0,   v: 0,  de: 1, bp: 0, ep: 0};

    tick();
    do_reset("rst_init");

    p1d = 4'b0011;
    sh1 = 1'b1;
    expect_snap("bad_dir", 0, -1, -1, 0, -1, -1, 0, 0, 0, -1, -1);
    tick();
    sh1 = 1'b0;
    check_snap();
    p1d = 4'b0001;
    tick();

    sh1 = 1'b1;
    expect_snap("spawn", 1, 238, 46, 0, -1, -1, 0, 0, 0, -1, -1);
    tick();
    check_snap();
    repeat (99) tick();
    sh1 = 1'b0;
    tick();
    sh1 = 1'b1;
    tick();
    sh1 = 1'b0;
    expect_snap("hold_refire", 1, 238, 46, 0, -1, -1, 0, 0, 0, -1, -1);
    tick();
    check_snap();

    repeat (9) do_step();
    step = 1'b1;
    expect_snap("move10", 1, 238, 66, 0, -1, -1, 0, 0, 0, -1, -1);
    tick();
    step = 1'b0;
    check_snap();

    for (int i = 0; i < 7; i++) begin
      hpos = 10'(ptab[i].h);
      vpos = 10'(ptab[i].v);
      de   = ptab[i].de[0];
      #1;
      cmp($sformatf("pix%0d.bullet", i), int'(bp), ptab[i].bp);
      cmp($sformatf("pix%0d.explode", i), int'(ep), ptab[i].ep);
    end
    de = 1'b0;
    tick();

    repeat (61) do_step();
    step = 1'b1;
    expect_snap("at190", 1, 238, 190, 0, -1, -1, 0, 0, 0, -1, -1);
    tick();
    step = 1'b0;
    check_snap();

    hpos = 10'd239; vpos = 10'd191; de = 1'b1; blk = 1'b1; dst = 1'b1;
    tick();
    de = 1'b0; blk = 1'b0; dst = 1'b0;
    tick();
    step = 1'b1;
    expect_snap("wall_hit", 2, 238, 190, 0, -1, -1, 0, 0, 1, 7, 6);
    tick();
    step = 1'b0;
    check_snap();
    expect_snap("wall_pulse_end", 2, 238, 190, 0, -1, -1, 0, 0, 0, -1, -1);
    tick();
    check_snap();

    repeat (6) do_step();
    step = 1'b1;
    expect_snap("expl7", 2, 238, 190, 0, -1, -1, 0, 0, 0, -1, -1);
    tick();
    step = 1'b0;
    check_snap();
    tick();
    step = 1'b1;
    expect_snap("expl8", 0, -1, -1, 0, -1, -1, 0, 0, 0, -1, -1);
    tick();
    step = 1'b0;
    check_snap();
    sh1 = 1'b1;
    expect_snap("refire", 1, 238, 46, 0, -1, -1, 0, 0, 0, -1, -1);
    tick();
    sh1 = 1'b0;
    check_snap();

    do_reset("rst_fly");

    p1x = 10'd100; p1y = 10'd7; p1d = 4'b0010;
    sh1 = 1'b1;
    expect_snap("up_spawn", 1, 114, 21, 0, -1, -1, 0, 0, 0, -1, -1);
    tick();
    sh1 = 1'b0;
    check_snap();
    repeat (9) do_step();
    step = 1'b1;
    expect_snap("up_y1", 1, 114, 1, 0, -1, -1, 0, 0, 0, -1, -1);
    tick();
    step = 1'b0;
    check_snap();
    tick();
    step = 1'b1;
    expect_snap("oob", 0, -1, -1, 0, -1, -1, 0, 0, 0, -1, -1);
    tick();
    step = 1'b0;
    check_snap();

    do_reset("rst_b");
    p1x = 10'd600; p1y = 10'd400; p1d = 4'b0001;
    p2x = 10'd224; p2y = 10'd26;  p2d = 4'b0001;
    sh2 = 1'b1;
    expect_snap("p2_spawn", 0, -1, -1, 1, 238, 40, 0, 0, 0, -1, -1);
    tick();
    sh2 = 1'b0;
    check_snap();
    hpos = 10'd240; vpos = 10'd42; de = 1'b1; blk = 1'b1; dst = 1'b1;
    tick();
    de = 1'b0; blk = 1'b0; dst = 1'b0;
    p1x = 10'd224; p1y = 10'd32;
    step = 1'b1;
    expect_snap("tank_hit", 0, -1, -1, 2, 238, 40, 1, 0, 0, -1, -1);
    tick();
    step = 1'b0;
    check_snap();
    expect_snap("hit_end", 0, -1, -1, 2, 238, 40, 0, 0, 0, -1, -1);
    tick();
    check_snap();
    hpos = 10'd239; vpos = 10'd41; de = 1'b1;
    #1;
    cmp("expl_pix.explode", int'(ep), 1);
    cmp("expl_pix.bullet", int'(bp), 0);
    de = 1'b0;
    do_reset("rst_expl");

    p1x = 10'd224; p1y = 10'd32;  p1d = 4'b0001;
    p2x = 10'd400; p2y = 10'd300; p2d = 4'b0001;
    sh1 = 1'b1; sh2 = 1'b1;
    expect_snap("both_spawn", 1, 238, 46, 1, 414, 314, 0, 0, 0, -1, -1);
    tick();
    sh1 = 1'b0; sh2 = 1'b0;
    check_snap();
    hpos = 10'd238; vpos = 10'd46; de = 1'b1; blk = 1'b1; dst = 1'b1;
    tick();
    hpos = 10'd414; vpos = 10'd314;
    tick();
    de = 1'b0; blk = 1'b0; dst = 1'b0;
    step = 1'b1;
    expect_snap("dual_d1", 2, 238, 46, 2, 414, 314, 0, 0, 1, 7, 1);
    tick();
    step = 1'b0;
    check_snap();
    expect_snap("dual_d2", 2, 238, 46, 2, 414, 314, 0, 0, 1, 13, 9);
    tick();
    check_snap();
    expect_snap("dual_end", 2, -1, -1, 2, -1, -1, 0, 0, 0, -1, -1);
    tick();
    check_snap();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
